cmos_pixel_packer: RTL and testbench
====================================

Name: cmos_pixel_packer

Overview:
- Sits directly downstream of the MIPI-DPHY-to-CMOS converter and upstream of the video buffer.
- Takes the 10-bit parallel pixel stream (fv/lv qualified, one pixel per clock) and packs two pixels per 32-bit word for the video buffer's 32-bit camera data input.
- Emits end-of-line and frame start/end markers.
- Measures frame width and height, and flags line-width mismatch, odd-length lines and truncated frames.

Parameters:
- PIX_W, 10, pixel width in bits; must be ≤ 16, each pixel is zero-extended to 16 bits.
- CNT_W, 16, width of the pixel and line counters; counters saturate at all-ones.

Ports:
- clk_i  in  1  pixel clock, same domain as the CMOS outputs.
- rst_i  in  1  asynchronous, active-high reset.
- en_i  in  1  capture enable; sampled only in IDLE.
- fv_i  in  1  frame valid from the CMOS stage.
- lv_i  in  1  line valid from the CMOS stage.
- pix_i  in  PIX_W  pixel data; valid when fv_i & lv_i.
- data_o  out  32  packed word: first pixel in [15:0], second pixel in [31:16].
- data_vld_o  out  1  one-cycle qualifier for data_o.
- eol_o  out  1  asserted with the last word of a line.
- sof_pl_o  out  1  one-cycle pulse on frame start.
- eof_pl_o  out  1  one-cycle pulse on frame end.
- frame_width_o  out  CNT_W  pixels per line of the first line of the last completed frame.
- frame_height_o  out  CNT_W  line count of the last completed frame.
- err_width_o  out  1  sticky flag: a line width differed from line 0 of the same frame.
- err_odd_o  out  1  sticky flag: a line with an odd pixel count was padded.
- err_trunc_o  out  1  sticky flag: fv fell while lv was high.

Behaviour:
- Reset: every output is 0; state = IDLE; half/hold registers are invalid; counters are 0. Reset mid-frame discards any partial words.
- Input stage: fv_i, lv_i and pix_i are registered once (fv_r, lv_r, pix_r). Edges are detected against a second delay (fv_rr, lv_rr).
- States:
  - IDLE: wait for a fv_r rising edge with en_i = 1. On that edge: sof_pl_o = 1 for one cycle, line counter cleared, go to FRAME. A rising edge with en_i = 0 is ignored for the whole frame.
  - FRAME: fv high, lv low. An lv_r rising edge goes to LINE and clears the pixel counter. A fv_r falling edge ends the frame: frame_width_o and frame_height_o update, eof_pl_o = 1, go to IDLE.
  - LINE: every cycle with lv_r = 1 consumes pix_r and increments the pixel counter.
    - If half is empty: half ← pix_r.
    - Otherwise: word = {zext(pix_r), zext(half)}, half cleared. If hold is valid, emit hold (data_vld_o = 1, eol_o = 0). Hold ← word.
  - LINE exit: lv_r falls, or fv_r falls with lv high.
    - If half is valid: emit hold if it is valid, hold ← {16'h0, zext(half)}, set err_odd_o, go to FLUSH.
    - Otherwise: emit hold with eol_o = 1 in that cycle and go straight to the line-end step.
  - FLUSH: emit hold with eol_o = 1, then run the line-end step.
- Line-end step:
  - Line counter increments.
  - Line 0 latches its pixel count as the reference width. Any later line with a different count sets err_width_o.
  - A zero-pixel line still counts as a line but emits no word.
- Latency: a word is emitted either when the next word completes, or 1–2 cycles after the line ends. data_vld_o never asserts outside a frame.
- Simultaneous lv and fv fall in the same cycle: the line is completed first (eol word), then eof_pl_o fires on the following cycle. FRAME is traversed for one cycle.
- fv falling while lv_r = 1: handled as a line end, then sets err_trunc_o.
- Flag clearing: the sticky error flags clear only at sof_pl_o. frame_* outputs hold their values until the next frame end.
- Pixel and line counters saturate at 2^CNT_W − 1 and do not wrap.

Decomposition:
- Shared package video_pkg: state encoding (IDLE, FRAME, LINE, FLUSH), PIX_W, CNT_W default, zero-extension width constant 16.
- One natural sub-module: pix_line_meter, holding the pixel/line counters, reference-width latch, mismatch and saturation logic. The packer FSM instantiates it.

Test Plan:
- Frame of 2 lines × 4 pixels (0x001, 0x002, 0x003, 0x3FF per line) -> per line: words 0x00020001 then 0x03FF0003 with eol on the second; sof/eof once each; frame_width = 4, frame_height = 2; no error flags.
- Line of 3 pixels (0x011, 0x022, 0x033) -> words 0x00220011, then 0x00000033 with eol on the following cycle (FLUSH); err_odd_o = 1.
- Lines of 4, 6, 4 pixels -> err_width_o = 1 after line 1; frame_width = 4, frame_height = 3; flag cleared at the next sof.
- fv and lv falling on the same cycle after a 2-pixel line -> eol word 0x....; eof_pl_o exactly one cycle later; err_trunc_o = 0. fv falling while lv stays high -> err_trunc_o = 1.
- en_i = 0 at the fv rise, raised mid-frame -> no outputs for that frame; the next frame is captured normally.
- rst_i pulsed mid-line with a half word pending -> all outputs 0; the next frame's first word contains no stale pixel.

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the camera pixel path: packer FSM states and the
// default pixel/counter widths.
package video_pkg;

  localparam int PIX_W_DEF = 10;
  localparam int CNT_W_DEF = 16;
  localparam int ZEXT_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_LINE  = 2'd2,
    ST_FLUSH = 2'd3
  } pack_state_e;

endpackage

// File: rtl/pix_line_meter.sv
// Pixel/line counters for one frame: latches line 0 as the reference width
// and reports lines whose pixel count differs from it.
import video_pkg::*;

module pix_line_meter #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             frame_start_i,
  input  logic             line_first_i,
  input  logic             pix_inc_i,
  input  logic             line_end_i,
  output logic [CNT_W-1:0] line_cnt_o,
  output logic [CNT_W-1:0] ref_width_o,
  output logic             width_mismatch_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] pix_cnt_q;
  logic [CNT_W-1:0] line_cnt_q;
  logic [CNT_W-1:0] ref_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      ref_q      <= '0;
    end else if (frame_start_i) begin
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      ref_q      <= '0;
    end else begin
      // The first pixel of a line is consumed in the cycle that opens it.
      if (line_first_i) begin
        pix_cnt_q <= CNT_W'(1);
      end else if (pix_inc_i && pix_cnt_q != CNT_MAX) begin
        pix_cnt_q <= pix_cnt_q + 1'b1;
      end
      if (line_end_i) begin
        if (line_cnt_q != CNT_MAX) line_cnt_q <= line_cnt_q + 1'b1;
        if (line_cnt_q == '0)      ref_q      <= pix_cnt_q;
      end
    end
  end

  assign width_mismatch_o = line_end_i && (line_cnt_q != '0) && (pix_cnt_q != ref_q);
  assign line_cnt_o       = line_cnt_q;
  assign ref_width_o      = ref_q;

endmodule

// File: rtl/cmos_pixel_packer.sv
// Packs the fv/lv-qualified CMOS pixel stream two pixels per 32-bit word,
// with line/frame markers, frame geometry and sticky error flags.
import video_pkg::*;

module cmos_pixel_packer #(
  parameter int PIX_W = PIX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             fv_i,
  input  logic             lv_i,
  input  logic [PIX_W-1:0] pix_i,
  output logic [31:0]      data_o,
  output logic             data_vld_o,
  output logic             eol_o,
  output logic             sof_pl_o,
  output logic             eof_pl_o,
  output logic [CNT_W-1:0] frame_width_o,
  output logic [CNT_W-1:0] frame_height_o,
  output logic             err_width_o,
  output logic             err_odd_o,
  output logic             err_trunc_o
);

  logic             fv_r_q, fv_rr_q, lv_r_q, lv_rr_q;
  logic [PIX_W-1:0] pix_r_q;
  pack_state_e      state_q;
  logic [ZEXT_W-1:0] half_q;
  logic              half_vld_q;
  logic [31:0]       hold_q;
  logic              hold_vld_q;
  logic [31:0]       data_q;
  logic              data_vld_q, eol_q, sof_q, eof_q;
  logic [CNT_W-1:0]  width_q, height_q;
  logic              err_width_q, err_odd_q, err_trunc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fv_r_q  <= 1'b0;
      fv_rr_q <= 1'b0;
      lv_r_q  <= 1'b0;
      lv_rr_q <= 1'b0;
      pix_r_q <= '0;
    end else begin
      fv_r_q  <= fv_i;
      fv_rr_q <= fv_r_q;
      lv_r_q  <= lv_i;
      lv_rr_q <= lv_r_q;
      pix_r_q <= pix_i;
    end
  end

  logic              fv_rise, lv_rise, pix_take;
  logic [ZEXT_W-1:0] pix_z;
  logic              frame_start, line_first, line_end;
  logic [CNT_W-1:0]  line_cnt, ref_width;
  logic              width_mismatch;

  assign fv_rise     = fv_r_q & ~fv_rr_q;
  assign lv_rise     = lv_r_q & ~lv_rr_q;
  assign pix_take    = fv_r_q & lv_r_q;
  assign pix_z       = ZEXT_W'(pix_r_q);
  assign frame_start = (state_q == ST_IDLE) && fv_rise && en_i;
  assign line_first  = (state_q == ST_FRAME) && fv_r_q && lv_rise;
  assign line_end    = ((state_q == ST_LINE) && !pix_take && !half_vld_q) ||
                       (state_q == ST_FLUSH);

  pix_line_meter #(.CNT_W(CNT_W)) u_meter (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .frame_start_i   (frame_start),
    .line_first_i    (line_first),
    .pix_inc_i       ((state_q == ST_LINE) && pix_take),
    .line_end_i      (line_end),
    .line_cnt_o      (line_cnt),
    .ref_width_o     (ref_width),
    .width_mismatch_o(width_mismatch)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      half_q      <= '0;
      half_vld_q  <= 1'b0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      data_q      <= '0;
      data_vld_q  <= 1'b0;
      eol_q       <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      width_q     <= '0;
      height_q    <= '0;
      err_width_q <= 1'b0;
      err_odd_q   <= 1'b0;
      err_trunc_q <= 1'b0;
    end else begin
      data_vld_q <= 1'b0;
      eol_q      <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      if (width_mismatch) err_width_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            sof_q       <= 1'b1;
            err_width_q <= 1'b0;
            err_odd_q   <= 1'b0;
            err_trunc_q <= 1'b0;
            half_vld_q  <= 1'b0;
            hold_vld_q  <= 1'b0;
            state_q     <= ST_FRAME;
          end
        end
        ST_FRAME: begin
          if (!fv_r_q) begin
            eof_q    <= 1'b1;
            width_q  <= ref_width;
            height_q <= line_cnt;
            state_q  <= ST_IDLE;
          end else if (lv_rise) begin
            half_q     <= pix_z;
            half_vld_q <= 1'b1;
            state_q    <= ST_LINE;
          end
        end
        ST_LINE: begin
          if (pix_take) begin
            if (!half_vld_q) begin
              half_q     <= pix_z;
              half_vld_q <= 1'b1;
            end else begin
              // The previous word is only released once a newer one exists,
              // so the final word of the line can carry eol.
              if (hold_vld_q) begin
                data_q     <= hold_q;
                data_vld_q <= 1'b1;
              end
              hold_q     <= {pix_z, half_q};
              hold_vld_q <= 1'b1;
              half_vld_q <= 1'b0;
            end
          end else begin
            if (lv_r_q) err_trunc_q <= 1'b1;
            if (half_vld_q) begin
              if (hold_vld_q) begin
                data_q     <= hold_q;
                data_vld_q <= 1'b1;
              end
              hold_q     <= {{ZEXT_W{1'b0}}, half_q};
              hold_vld_q <= 1'b1;
              half_vld_q <= 1'b0;
              err_odd_q  <= 1'b1;
              state_q    <= ST_FLUSH;
            end else begin
              if (hold_vld_q) begin
                data_q     <= hold_q;
                data_vld_q <= 1'b1;
                eol_q      <= 1'b1;
              end
              hold_vld_q <= 1'b0;
              state_q    <= ST_FRAME;
            end
          end
        end
        ST_FLUSH: begin
          data_q     <= hold_q;
          data_vld_q <= 1'b1;
          eol_q      <= 1'b1;
          hold_vld_q <= 1'b0;
          state_q    <= ST_FRAME;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_o         = data_q;
  assign data_vld_o     = data_vld_q;
  assign eol_o          = eol_q;
  assign sof_pl_o       = sof_q;
  assign eof_pl_o       = eof_q;
  assign frame_width_o  = width_q;
  assign frame_height_o = height_q;
  assign err_width_o    = err_width_q;
  assign err_odd_o      = err_odd_q;
  assign err_trunc_o    = err_trunc_q;

endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Scoreboard bench for cmos_pixel_packer: stimulus queues expected
// sof/word/eof events, a negedge monitor pops and compares them.
module tb_cmos_pixel_packer;

  typedef enum int {EV_SOF = 0, EV_WORD = 1, EV_EOF = 2} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [31:0] data;
    logic        eol;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        fv = 1'b0;
  logic        lv = 1'b0;
  logic [9:0]  pix = '0;
  logic [31:0] data_o;
  logic        data_vld_o, eol_o, sof_pl_o, eof_pl_o;
  logic [15:0] frame_width_o, frame_height_o;
  logic        err_width_o, err_odd_o, err_trunc_o;

  ev_t        exp_q[$];
  logic [9:0] px_q[$];
  bit         expect_on = 1'b1;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         eol_cyc = 0;
  int         eof_cyc = 0;

  cmos_pixel_packer #(.PIX_W(10), .CNT_W(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .fv_i          (fv),
    .lv_i          (lv),
    .pix_i         (pix),
    .data_o        (data_o),
    .data_vld_o    (data_vld_o),
    .eol_o         (eol_o),
    .sof_pl_o      (sof_pl_o),
    .eof_pl_o      (eof_pl_o),
    .frame_width_o (frame_width_o),
    .frame_height_o(frame_height_o),
    .err_width_o   (err_width_o),
    .err_odd_o     (err_odd_o),
    .err_trunc_o   (err_trunc_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_ev(input ev_kind_e k, input logic [31:0] d, input logic e);
    ev_t ev;
    ev.kind = k;
    ev.data = d;
    ev.eol  = e;
    if (expect_on) exp_q.push_back(ev);
  endtask

  task automatic expect_ev(input ev_kind_e k, input logic [31:0] d, input logic e);
    ev_t ev;
    if (exp_q.size() == 0) begin
      check($sformatf("unexpected_output_kind%0d", int'(k)), 32'd1, 32'd0);
    end else begin
      ev = exp_q.pop_front();
      check("event_kind", 32'(int'(k)), 32'(int'(ev.kind)));
      if (ev.kind == EV_WORD && k == EV_WORD) begin
        check("word_data", d, ev.data);
        check("word_eol", 32'(e), 32'(ev.eol));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sof_pl_o) expect_ev(EV_SOF, 32'h0, 1'b0);
      if (data_vld_o) begin
        if (eol_o) eol_cyc = cyc;
        expect_ev(EV_WORD, data_o, eol_o);
      end
      if (eof_pl_o) begin
        eof_cyc = cyc;
        expect_ev(EV_EOF, 32'h0, 1'b0);
      end
    end
  end

  task automatic start_frame();
    @(posedge clk); #1 fv = 1'b1;
    if (en) push_ev(EV_SOF, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
  endtask

  task automatic end_frame();
    @(posedge clk); #1 fv = 1'b0;
    push_ev(EV_EOF, 32'h0, 1'b0);
    repeat (4) @(posedge clk);
  endtask

  // end_mode: 0 normal line end, 1 fv and lv fall together, 2 fv falls with lv high
  task automatic send_line(input int end_mode);
    int n = px_q.size();
    for (int i = 0; i < n; i += 2) begin
      logic [31:0] w;
      if (i + 1 < n) w = {6'h0, px_q[i+1], 6'h0, px_q[i]};
      else           w = {22'h0, px_q[i]};
      push_ev(EV_WORD, w, (i + 2 >= n));
    end
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 lv = 1'b1; pix = px_q[i];
    end
    @(posedge clk); #1 pix = 10'h3FF;
    if (end_mode == 0) lv = 1'b0;
    if (end_mode == 1) begin lv = 1'b0; fv = 1'b0; end
    if (end_mode == 2) fv = 1'b0;
    if (end_mode != 0) push_ev(EV_EOF, 32'h0, 1'b0);
    if (end_mode == 2) begin
      @(posedge clk); #1 lv = 1'b0;
    end
    @(posedge clk); #1 pix = '0;
    repeat (3) @(posedge clk);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", data_o, 32'h0);
    check("reset_flags", {27'h0, data_vld_o, eol_o, sof_pl_o, eof_pl_o, err_width_o},
          32'h0);
    check("reset_geom", {frame_width_o, frame_height_o}, 32'h0);
    rst = 1'b0;
    en  = 1'b1;
    repeat (2) @(posedge clk);

    // 2 lines x 4 pixels
    start_frame();
    px_q = '{10'h001, 10'h002, 10'h003, 10'h3FF};
    send_line(0);
    send_line(0);
    end_frame();
    drain("drain_2x4");
    check("2x4_width", 32'(frame_width_o), 32'd4);
    check("2x4_height", 32'(frame_height_o), 32'd2);
    check("2x4_errs", {29'h0, err_width_o, err_odd_o, err_trunc_o}, 32'h0);

    // single odd line of 3 pixels, padded through FLUSH
    start_frame();
    px_q = '{10'h011, 10'h022, 10'h033};
    send_line(0);
    end_frame();
    drain("drain_odd");
    check("odd_flag", 32'(err_odd_o), 32'd1);
    check("odd_width", 32'(frame_width_o), 32'd3);
    check("odd_height", 32'(frame_height_o), 32'd1);

    // lines of 4, 6, 4 pixels
    start_frame();
    check("odd_cleared_at_sof", 32'(err_odd_o), 32'd0);
    px_q = '{10'h101, 10'h102, 10'h103, 10'h104};
    send_line(0);
    px_q = '{10'h201, 10'h202, 10'h203, 10'h204, 10'h205, 10'h206};
    send_line(0);
    check("width_err_after_line1", 32'(err_width_o), 32'd1);
    px_q = '{10'h301, 10'h302, 10'h303, 10'h304};
    send_line(0);
    end_frame();
    drain("drain_464");
    check("464_width", 32'(frame_width_o), 32'd4);
    check("464_height", 32'(frame_height_o), 32'd3);
    check("464_width_err", 32'(err_width_o), 32'd1);

    // fv and lv fall together after a 2-pixel line
    start_frame();
    drain("drain_sof_sim");
    check("width_err_cleared_at_sof", 32'(err_width_o), 32'd0);
    px_q = '{10'h155, 10'h2AA};
    send_line(1);
    drain("drain_sim_fall");
    check("eof_one_after_eol", 32'(eof_cyc - eol_cyc), 32'd1);
    check("sim_fall_trunc", 32'(err_trunc_o), 32'd0);
    check("sim_fall_geom", {frame_width_o, frame_height_o}, {16'd2, 16'd1});

    // fv falls while lv stays high
    start_frame();
    px_q = '{10'h005, 10'h006};
    send_line(2);
    drain("drain_trunc");
    check("trunc_flag", 32'(err_trunc_o), 32'd1);
    check("trunc_odd", 32'(err_odd_o), 32'd0);

    // en low at the fv rise: whole frame ignored, even after en rises
    en = 1'b0;
    expect_on = 1'b0;
    start_frame();
    en = 1'b1;
    px_q = '{10'h0AA, 10'h0BB};
    send_line(0);
    @(posedge clk); #1 fv = 1'b0;
    repeat (5) @(posedge clk);
    expect_on = 1'b1;
    check("disabled_frame_geom", {frame_width_o, frame_height_o}, {16'd2, 16'd1});
    check("disabled_frame_trunc_kept", 32'(err_trunc_o), 32'd1);

    start_frame();
    px_q = '{10'h0AB, 10'h0CD, 10'h0EF, 10'h012};
    send_line(0);
    end_frame();
    drain("drain_after_disabled");
    check("after_disabled_geom", {frame_width_o, frame_height_o}, {16'd4, 16'd1});

    // reset mid-line with a half word pending
    start_frame();
    drain("drain_sof_rst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 lv = 1'b1; pix = 10'h3C0 + 10'(i);
    end
    @(posedge clk); #1 rst = 1'b1; fv = 1'b0; lv = 1'b0; pix = '0;
    #1;
    check("midrst_data", data_o, 32'h0);
    check("midrst_flags", {25'h0, data_vld_o, eol_o, sof_pl_o, eof_pl_o,
          err_width_o, err_odd_o, err_trunc_o}, 32'h0);
    check("midrst_geom", {frame_width_o, frame_height_o}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    start_frame();
    px_q = '{10'h101, 10'h202};
    send_line(0);
    end_frame();
    drain("drain_post_rst");
    check("post_rst_geom", {frame_width_o, frame_height_o}, {16'd2, 16'd1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
